feature_row_reader: RTL and testbench

- Read-side responder for the two ping-pong feature buffer banks feeding the vertical window shifter.
- Each single-cycle feature_en_b request reads one row slice from bank b: Tn maps × KERNEL_SIZE pixels × FEATURE_WIDTH bits.
- Each row slice is returned on dia_b exactly one cycle after the request, which is when the shifter samples it.
- Walks K rows per window column, advances columns, tracks bank full/empty state, and releases each bank to the loader once it is fully consumed.

---
 rtl/feature_row_reader_pkg.sv | 34 +++
 rtl/feature_row_reader_if.sv | 66 ++++++
 rtl/feature_row_reader_bank_addr_gen.sv | 93 +++++++++
 rtl/feature_row_reader.sv | 108 ++++++++++
 tb/tb_feature_row_reader.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/feature_row_reader_pkg.sv
// Shared definitions for the feature row reader.
//   - default geometry of a row slice (maps x pixels x bits) and address width
//   - ROW_W: width of one row slice bus
//   - clamp helpers applied when the configuration is latched
package feature_row_reader_pkg;

    localparam int TN_DEF            = 4;
    localparam int KERNEL_SIZE_DEF   = 3;
    localparam int FEATURE_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF    = 10;
    localparam int NUM_BANKS         = 2;

    localparam int ROW_W = TN_DEF * KERNEL_SIZE_DEF * FEATURE_WIDTH_DEF;

    // Rows per window column: at least one, never more than the slice holds.
    function automatic logic [7:0] clamp_kernel(input logic [7:0] k,
                                                input logic [7:0] k_max);
        logic [7:0] res;
        if (k == 8'd0) begin
            res = 8'd1;
        end else if (k > k_max) begin
            res = k_max;
        end else begin
            res = k;
        end
        return res;
    endfunction

    // A bank fill always holds at least one window column.
    function automatic logic [7:0] clamp_cols(input logic [7:0] c);
        return (c == 8'd0) ? 8'd1 : c;
    endfunction

endpackage

// File: rtl/feature_row_reader_if.sv
// Bus bundle between the feature row reader and its surroundings
// (configuration, loader handshake, shifter requests, buffer read port).
//   slave  : view taken by feature_row_reader
//   master : view taken by the environment (loader, shifter, buffers)
interface feature_row_reader_if
    import feature_row_reader_pkg::*;
#(
    parameter int RW = ROW_W,
    parameter int AW = ADDR_WIDTH_DEF
) ();

    // configuration
    logic          cfg_valid;
    logic [7:0]    kernel_size;
    logic [AW-1:0] row_stride;
    logic [7:0]    num_cols;

    // loader handshake
    logic          bank_load_done_0;
    logic          bank_load_done_1;
    logic          bank_full_0;
    logic          bank_full_1;
    logic          bank_release_0;
    logic          bank_release_1;

    // shifter requests and returned row slices
    logic          feature_en_0;
    logic          feature_en_1;
    logic [RW-1:0] dia_0;
    logic [RW-1:0] dia_1;
    logic          dia_valid_0;
    logic          dia_valid_1;

    // feature buffer read ports
    logic          rd_en_0;
    logic          rd_en_1;
    logic [AW-1:0] rd_addr_0;
    logic [AW-1:0] rd_addr_1;
    logic [RW-1:0] rd_data_0;
    logic [RW-1:0] rd_data_1;

    logic          err_empty_rd;

    modport slave (
        input  cfg_valid, kernel_size, row_stride, num_cols,
        input  bank_load_done_0, bank_load_done_1,
        input  feature_en_0, feature_en_1,
        input  rd_data_0, rd_data_1,
        output bank_full_0, bank_full_1, bank_release_0, bank_release_1,
        output rd_en_0, rd_en_1, rd_addr_0, rd_addr_1,
        output dia_0, dia_1, dia_valid_0, dia_valid_1,
        output err_empty_rd
    );

    modport master (
        output cfg_valid, kernel_size, row_stride, num_cols,
        output bank_load_done_0, bank_load_done_1,
        output feature_en_0, feature_en_1,
        output rd_data_0, rd_data_1,
        input  bank_full_0, bank_full_1, bank_release_0, bank_release_1,
        input  rd_en_0, rd_en_1, rd_addr_0, rd_addr_1,
        input  dia_0, dia_1, dia_valid_0, dia_valid_1,
        input  err_empty_rd
    );

endinterface

// File: rtl/feature_row_reader_bank_addr_gen.sv
// Address walker for one feature buffer bank.
//   Inputs : clk, rst, feature_en (row request), load_done (bank filled),
//            k_cfg / num_cols_cfg / row_stride (latched, already clamped)
//   Outputs: rd_en, rd_addr (combinational read port drive), full,
//            release_pulse (one cycle after last read), dia_valid
// Walks K rows of a column (stepping by row_stride) and then moves to the
// next column; the address is row_base + col so no multiplier is needed.
module bank_addr_gen
    import feature_row_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  feature_en,
    input  logic                  load_done,
    input  logic [7:0]            k_cfg,
    input  logic [7:0]            num_cols_cfg,
    input  logic [ADDR_WIDTH-1:0] row_stride,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  full,
    output logic                  release_pulse,
    output logic                  dia_valid
);

    logic [7:0]            row_reg, row_next;
    logic [7:0]            col_reg, col_next;
    logic [ADDR_WIDTH-1:0] row_base_reg, row_base_next;
    logic                  full_reg, full_next;
    logic                  release_reg, release_next;
    logic                  valid_reg;

    logic last_row;
    logic last_col;

    assign rd_en    = feature_en & full_reg;
    assign rd_addr  = row_base_reg + ADDR_WIDTH'(col_reg);
    assign last_row = (row_reg == (k_cfg - 8'd1));
    assign last_col = (col_reg == (num_cols_cfg - 8'd1));

    always_comb begin
        row_next      = row_reg;
        col_next      = col_reg;
        row_base_next = row_base_reg;
        full_next     = full_reg;
        release_next  = 1'b0;
        if (rd_en) begin
            if (!last_row) begin
                row_next      = row_reg + 8'd1;
                row_base_next = row_base_reg + row_stride;
            end else if (!last_col) begin
                row_next      = 8'd0;
                row_base_next = '0;
                col_next      = col_reg + 8'd1;
            end else begin
                row_next      = 8'd0;
                col_next      = 8'd0;
                row_base_next = '0;
                full_next     = 1'b0;
                release_next  = 1'b1;
            end
        end
        // A refill landing on the final read keeps the bank full; the
        // release pulse for the consumed data still goes out.
        if (load_done) begin
            full_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_reg      <= 8'd0;
            col_reg      <= 8'd0;
            row_base_reg <= '0;
            full_reg     <= 1'b0;
            release_reg  <= 1'b0;
            valid_reg    <= 1'b0;
        end else begin
            row_reg      <= row_next;
            col_reg      <= col_next;
            row_base_reg <= row_base_next;
            full_reg     <= full_next;
            release_reg  <= release_next;
            valid_reg    <= rd_en;
        end
    end

    assign full          = full_reg;
    assign release_pulse = release_reg;
    assign dia_valid     = valid_reg;

endmodule

// File: rtl/feature_row_reader.sv
// Read-side responder for the two ping-pong feature buffer banks that feed
// the vertical window shifter.
//   clk, rst : clock and synchronous active-high reset
//   bus      : feature_row_reader_if.slave -- config, loader handshake,
//              shifter requests/row slices, buffer read ports, error flag
// Each request reads one row slice; the buffer's registered output is passed
// straight to the shifter, so the slice is valid the cycle after the request.
module feature_row_reader
    import feature_row_reader_pkg::*;
#(
    parameter int Tn            = TN_DEF,
    parameter int KERNEL_SIZE   = KERNEL_SIZE_DEF,
    parameter int FEATURE_WIDTH = FEATURE_WIDTH_DEF,
    parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    feature_row_reader_if.slave  bus
);

    localparam int         RW    = Tn * KERNEL_SIZE * FEATURE_WIDTH;
    localparam logic [7:0] K_MAX = 8'(KERNEL_SIZE);

    logic [7:0]            k_reg, k_next;
    logic [7:0]            cols_reg, cols_next;
    logic [ADDR_WIDTH-1:0] stride_reg, stride_next;
    logic                  err_reg, err_next;

    logic [NUM_BANKS-1:0]  feature_en;
    logic [NUM_BANKS-1:0]  load_done;
    logic [NUM_BANKS-1:0]  full;
    logic [NUM_BANKS-1:0]  release_w;
    logic [NUM_BANKS-1:0]  rd_en;
    logic [NUM_BANKS-1:0]  dia_valid;
    logic [ADDR_WIDTH-1:0] rd_addr [NUM_BANKS];

    assign feature_en = {bus.feature_en_1, bus.feature_en_0};
    assign load_done  = {bus.bank_load_done_1, bus.bank_load_done_0};

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            bank_addr_gen #(
                .ADDR_WIDTH (ADDR_WIDTH)
            ) u_bank (
                .clk           (clk),
                .rst           (rst),
                .feature_en    (feature_en[gi]),
                .load_done     (load_done[gi]),
                .k_cfg         (k_reg),
                .num_cols_cfg  (cols_reg),
                .row_stride    (stride_reg),
                .rd_en         (rd_en[gi]),
                .rd_addr       (rd_addr[gi]),
                .full          (full[gi]),
                .release_pulse (release_w[gi]),
                .dia_valid     (dia_valid[gi])
            );
        end
    endgenerate

    // Config may only change while nothing is buffered, so a bank is always
    // walked with the geometry it was loaded for.
    always_comb begin
        k_next      = k_reg;
        cols_next   = cols_reg;
        stride_next = stride_reg;
        if (bus.cfg_valid && (full == '0)) begin
            k_next      = clamp_kernel(bus.kernel_size, K_MAX);
            cols_next   = clamp_cols(bus.num_cols);
            stride_next = bus.row_stride;
        end
        err_next = err_reg | (|(feature_en & ~full));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_reg      <= K_MAX;
            cols_reg   <= 8'd1;
            stride_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            k_reg      <= k_next;
            cols_reg   <= cols_next;
            stride_reg <= stride_next;
            err_reg    <= err_next;
        end
    end

    logic [RW-1:0] row_0;
    logic [RW-1:0] row_1;
    assign row_0 = bus.rd_data_0;
    assign row_1 = bus.rd_data_1;

    assign bus.rd_en_0        = rd_en[0];
    assign bus.rd_en_1        = rd_en[1];
    assign bus.rd_addr_0      = rd_addr[0];
    assign bus.rd_addr_1      = rd_addr[1];
    assign bus.dia_0          = row_0;
    assign bus.dia_1          = row_1;
    assign bus.dia_valid_0    = dia_valid[0];
    assign bus.dia_valid_1    = dia_valid[1];
    assign bus.bank_full_0    = full[0];
    assign bus.bank_full_1    = full[1];
    assign bus.bank_release_0 = release_w[0];
    assign bus.bank_release_1 = release_w[1];
    assign bus.err_empty_rd   = err_reg;

endmodule

// File: tb/tb_feature_row_reader.sv
module tb_feature_row_reader;
    import feature_row_reader_pkg::*;

    localparam int AW   = 10;
    localparam int RW   = 192;
    localparam int KMAX = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    feature_row_reader_if bus ();

    feature_row_reader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Row slice content for (bank, address): each 16-bit pixel tags the bank,
    // pixel index and address so misrouted or stale data is visible.
    function automatic logic [RW-1:0] row_data(input int bank, input int addr);
        logic [RW-1:0] v;
        logic [3:0]    pi;
        logic [9:0]    ai;
        v  = '0;
        ai = 10'(addr);
        for (int p = 0; p < 12; p++) begin
            pi = 4'(p);
            v[p*16 +: 16] = {bank[0], pi, ai, 1'b1};
        end
        return v;
    endfunction

    // Feature buffer model: registered read, one cycle latency.
    always @(posedge clk) begin
        if (bus.rd_en_0 === 1'b1) bus.rd_data_0 <= row_data(0, int'(bus.rd_addr_0));
        if (bus.rd_en_1 === 1'b1) bus.rd_data_1 <= row_data(1, int'(bus.rd_addr_1));
    end

    task automatic check_val(input string tag, input logic [RW-1:0] got,
                             input logic [RW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int mq[2][$];
    bit mfull[2];
    bit exp_valid[2];
    bit exp_rel[2];
    int exp_addr[2];
    bit merr;
    int mk, mcols, mstride;

    int cfg_k, cfg_s, cfg_c;
    int got_addr0[$];
    int rel_cnt0;

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            mq[b].delete();
            mfull[b]     = 0;
            exp_valid[b] = 0;
            exp_rel[b]   = 0;
            exp_addr[b]  = 0;
        end
        merr    = 0;
        mk      = KMAX;
        mcols   = 1;
        mstride = 0;
    endtask

    // A freshly loaded bank is read column by column, K rows per column.
    task automatic build_queue(input int b);
        mq[b].delete();
        for (int c = 0; c < mcols; c++)
            for (int r = 0; r < mk; r++)
                mq[b].push_back((r * mstride + c) % 1024);
    endtask

    task automatic model_update(input bit f0, f1, l0, l1, cv, r);
        bit f[2];
        bit l[2];
        bit cfg_ok;
        if (r) begin
            model_reset();
            return;
        end
        f[0] = f0; f[1] = f1; l[0] = l0; l[1] = l1;
        cfg_ok = cv && !mfull[0] && !mfull[1];
        for (int b = 0; b < 2; b++) begin
            exp_valid[b] = 0;
            exp_rel[b]   = 0;
            if (f[b]) begin
                if (mfull[b]) begin
                    exp_addr[b]  = mq[b].pop_front();
                    exp_valid[b] = 1;
                    if (mq[b].size() == 0) begin
                        mfull[b]   = 0;
                        exp_rel[b] = 1;
                    end
                end else begin
                    merr = 1;
                end
            end
        end
        if (cfg_ok) begin
            mk      = (cfg_k == 0) ? 1 : ((cfg_k > KMAX) ? KMAX : cfg_k);
            mcols   = (cfg_c == 0) ? 1 : cfg_c;
            mstride = cfg_s;
        end
        for (int b = 0; b < 2; b++) begin
            if (l[b] && !mfull[b]) begin
                mfull[b] = 1;
                build_queue(b);
            end
        end
    endtask

    // One clock cycle: drive, check combinational read port, advance, check
    // registered outputs.
    task automatic step(input bit f0, f1, l0, l1, cv, r);
        bus.feature_en_0     = f0;
        bus.feature_en_1     = f1;
        bus.bank_load_done_0 = l0;
        bus.bank_load_done_1 = l1;
        bus.cfg_valid        = cv;
        bus.kernel_size      = 8'(cfg_k);
        bus.row_stride       = 10'(cfg_s);
        bus.num_cols         = 8'(cfg_c);
        rst                  = r;
        @(negedge clk);
        check_val("rd_en_0", RW'(bus.rd_en_0), RW'(f0 && mfull[0]));
        check_val("rd_en_1", RW'(bus.rd_en_1), RW'(f1 && mfull[1]));
        if (f0 && mfull[0]) check_val("rd_addr_0", RW'(bus.rd_addr_0), RW'(mq[0][0]));
        if (f1 && mfull[1]) check_val("rd_addr_1", RW'(bus.rd_addr_1), RW'(mq[1][0]));
        if (bus.rd_en_0 === 1'b1) got_addr0.push_back(int'(bus.rd_addr_0));
        $display("txn t=%0t rst=%0d cfg=%0d k=%0d s=%0d c=%0d ld=%0d%0d fe=%0d%0d addr0=%0d addr1=%0d",
                 $time, r, cv, cfg_k, cfg_s, cfg_c, l1, l0, f1, f0, bus.rd_addr_0, bus.rd_addr_1);
        @(posedge clk);
        model_update(f0, f1, l0, l1, cv, r);
        #1;
        check_val("full_0", RW'(bus.bank_full_0), RW'(mfull[0]));
        check_val("full_1", RW'(bus.bank_full_1), RW'(mfull[1]));
        check_val("release_0", RW'(bus.bank_release_0), RW'(exp_rel[0]));
        check_val("release_1", RW'(bus.bank_release_1), RW'(exp_rel[1]));
        check_val("dia_valid_0", RW'(bus.dia_valid_0), RW'(exp_valid[0]));
        check_val("dia_valid_1", RW'(bus.dia_valid_1), RW'(exp_valid[1]));
        if (exp_valid[0]) check_val("dia_0", bus.dia_0, row_data(0, exp_addr[0]));
        if (exp_valid[1]) check_val("dia_1", bus.dia_1, row_data(1, exp_addr[1]));
        check_val("err_empty_rd", RW'(bus.err_empty_rd), RW'(merr));
        if (bus.bank_release_0 === 1'b1) rel_cnt0++;
    endtask

    task automatic set_cfg(input int k, input int s, input int c);
        cfg_k = k; cfg_s = s; cfg_c = c;
    endtask

    initial begin
        int exp1[6];
        exp1 = '{0, 16, 32, 1, 17, 33};
        set_cfg(0, 0, 0);
        bus.feature_en_0 = 0; bus.feature_en_1 = 0;
        bus.bank_load_done_0 = 0; bus.bank_load_done_1 = 0;
        bus.cfg_valid = 0; bus.kernel_size = 0; bus.row_stride = 0; bus.num_cols = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_val("reset_full_0", RW'(bus.bank_full_0), RW'(0));
        check_val("reset_full_1", RW'(bus.bank_full_1), RW'(0));
        check_val("reset_valid_0", RW'(bus.dia_valid_0), RW'(0));
        check_val("reset_release_0", RW'(bus.bank_release_0), RW'(0));
        check_val("reset_err", RW'(bus.err_empty_rd), RW'(0));

        // K=3, stride 16, two columns, six back-to-back reads of bank 0
        set_cfg(3, 16, 2);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0);
        got_addr0.delete();
        rel_cnt0 = 0;
        repeat (6) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check_val("t1_nreads", RW'(got_addr0.size()), RW'(6));
        for (int i = 0; i < 6 && i < got_addr0.size(); i++)
            check_val("t1_addr", RW'(got_addr0[i]), RW'(exp1[i]));
        check_val("t1_release_cnt", RW'(rel_cnt0), RW'(1));
        check_val("t1_full_0", RW'(bus.bank_full_0), RW'(0));

        // request to a bank that was never loaded
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check_val("t2_err_sticky", RW'(bus.err_empty_rd), RW'(1));

        // both banks, K=2, stride 8, one column, simultaneous requests
        step(0, 0, 0, 0, 0, 1);
        set_cfg(2, 8, 1);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0, 0);
        repeat (2) step(1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // refill coincident with the final read of bank 0
        set_cfg(3, 16, 2);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0);
        repeat (5) step(1, 0, 0, 0, 0, 0);
        rel_cnt0 = 0;
        step(1, 0, 1, 0, 0, 0);
        check_val("t4_release_cnt", RW'(rel_cnt0), RW'(1));
        check_val("t4_full_kept", RW'(bus.bank_full_0), RW'(1));
        repeat (6) step(1, 0, 0, 0, 0, 0);

        // kernel_size clamp, and config ignored while a bank is full
        set_cfg(7, 4, 1);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0);
        set_cfg(2, 5, 3);
        step(0, 0, 0, 0, 1, 0);
        rel_cnt0 = 0;
        repeat (3) step(1, 0, 0, 0, 0, 0);
        check_val("t5_release_after_3", RW'(rel_cnt0), RW'(1));

        // reset in the middle of a bank
        step(0, 0, 0, 0, 0, 1);
        set_cfg(3, 16, 2);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0, 0, 0);
        rel_cnt0 = 0;
        step(0, 0, 0, 0, 0, 1);
        check_val("t6_no_release", RW'(rel_cnt0), RW'(0));
        step(1, 0, 0, 0, 0, 0);
        check_val("t6_err", RW'(bus.err_empty_rd), RW'(1));

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            bit cv;
            cv = ($urandom_range(0, 9) == 0);
            if (cv) set_cfg($urandom_range(0, 7), $urandom_range(0, 1023), $urandom_range(0, 3));
            step($urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 cv, $urandom_range(0, 99) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
